// File: rtl/i2c_slave_passcode.sv
// Write-only I2C target that unlocks on a six-byte passcode and gates OTP commands.
// Optional I2C_SLV_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
module i2c_slave_passcode #(
    parameter logic [6:0]  DEV_ADDR     = 7'h0A,
    parameter logic [7:0]  REG_PASSCODE = 8'h05,
    parameter logic [7:0]  REG_OTP      = 8'h04,
    parameter logic [47:0] PASSCODE     = 48'h50_48_53_47_4E_58,
    parameter logic [7:0]  CMD_RD       = 8'h00,
    parameter logic [7:0]  CMD_WR       = 8'h11,
    parameter logic [7:0]  CMD_NOP      = 8'h01
) (
    input  logic       clk_sda,
    input  logic       rst_n,
    input  logic       i2c_scl,
    input  logic       i2c_sda_in,
    output logic       i2c_sda_oe,
    output logic       unlocked,
    output logic [7:0] otp_cmd,
    output logic       otp_rd_pulse,
    output logic       otp_wr_pulse,
    output logic       cmd_reject,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_REG_ADDR,
        S_REG_ACK, S_DATA, S_DATA_ACK, S_IGNORE
    } state_t;

    logic r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
    logic r_scl_d, r_sda_d;
    logic w_scl, w_sda;

    // Synchronizers reset to the idle-bus level so reset release makes no edge
    always_ff @(posedge clk_sda or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_scl_s1 <= i2c_scl;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= i2c_sda_in;
            r_sda_s2 <= r_sda_s1;
        end
    end

`ifdef I2C_SLV_GLITCH_FILTER_EN
    logic [1:0] r_scl_h, r_sda_h;
    logic       r_scl_f, r_sda_f;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge clk_sda or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_h <= 2'b11;
            r_sda_h <= 2'b11;
            r_scl_f <= 1'b1;
            r_sda_f <= 1'b1;
        end else begin
            r_scl_h <= {r_scl_h[0], r_scl_s2};
            r_sda_h <= {r_sda_h[0], r_sda_s2};
            r_scl_f <= maj3(r_scl_s2, r_scl_h[0], r_scl_h[1]);
            r_sda_f <= maj3(r_sda_s2, r_sda_h[0], r_sda_h[1]);
        end
    end

    assign w_scl = r_scl_f;
    assign w_sda = r_sda_f;
`else
    assign w_scl = r_scl_s2;
    assign w_sda = r_sda_s2;
`endif

    always_ff @(posedge clk_sda or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    logic w_scl_rise, w_scl_fall, w_start, w_stop;

    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & ~w_sda & r_sda_d;
    assign w_stop     = w_scl & r_scl_d & w_sda & ~r_sda_d;

    state_t     r_state;
    logic [2:0] r_cnt;
    logic       r_full;
    logic [7:0] r_shift;
    logic       r_reg_otp;
    logic [2:0] r_idx;
    logic       r_unlocked;
    logic [7:0] r_otp_cmd;
    logic       r_rd, r_wr, r_rej;
    logic       r_oe, r_busy;

    logic       w_in_byte, w_bit, w_byte_end, w_match;
    logic [2:0] w_idx_eff;
    logic [7:0] w_exp;

    function automatic logic [7:0] pass_byte(input logic [2:0] i);
        case (i)
            3'd0:    return PASSCODE[47:40];
            3'd1:    return PASSCODE[39:32];
            3'd2:    return PASSCODE[31:24];
            3'd3:    return PASSCODE[23:16];
            3'd4:    return PASSCODE[15:8];
            3'd5:    return PASSCODE[7:0];
            default: return 8'h00;
        endcase
    endfunction

    assign w_in_byte  = (r_state == S_DEV_ADDR) | (r_state == S_REG_ADDR) |
                        (r_state == S_DATA);
    assign w_bit      = w_in_byte & w_scl_rise & ~r_full;
    assign w_byte_end = w_in_byte & w_scl_fall & r_full;
    // An unlocked device relocks first, so the byte is judged from index 0
    assign w_idx_eff  = r_unlocked ? 3'd0 : r_idx;
    assign w_exp      = pass_byte(w_idx_eff);
    assign w_match    = (r_shift == w_exp);

    always_ff @(posedge clk_sda or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_full     <= 1'b0;
            r_shift    <= 8'h00;
            r_reg_otp  <= 1'b0;
            r_idx      <= 3'd0;
            r_unlocked <= 1'b0;
            r_otp_cmd  <= CMD_NOP;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_rej      <= 1'b0;
            r_oe       <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rd  <= 1'b0;
            r_wr  <= 1'b0;
            r_rej <= 1'b0;
            if (w_start) begin
                r_state <= S_DEV_ADDR;
                r_cnt   <= 3'd0;
                r_full  <= 1'b0;
                r_shift <= 8'h00;
                r_oe    <= 1'b0;
                r_busy  <= 1'b1;
            end else if (w_stop) begin
                r_state <= S_IDLE;
                r_cnt   <= 3'd0;
                r_full  <= 1'b0;
                r_oe    <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                if (w_bit) begin
                    r_shift <= {r_shift[6:0], w_sda};
                    r_cnt   <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) r_full <= 1'b1;
                end
                if (w_byte_end) r_full <= 1'b0;
                unique case (r_state)
                    S_IDLE, S_IGNORE: ;
                    S_DEV_ADDR: if (w_byte_end) begin
                        if (r_shift == {DEV_ADDR, 1'b0}) begin
                            r_state <= S_DEV_ACK;
                            r_oe    <= 1'b1;
                        end else begin
                            r_state <= S_IGNORE;
                        end
                    end
                    S_REG_ADDR: if (w_byte_end) begin
                        if (r_shift == REG_PASSCODE || r_shift == REG_OTP) begin
                            r_reg_otp <= (r_shift == REG_OTP);
                            r_state   <= S_REG_ACK;
                            r_oe      <= 1'b1;
                        end else begin
                            r_state <= S_IGNORE;
                        end
                    end
                    S_DATA: if (w_byte_end) begin
                        r_state <= S_DATA_ACK;
                        r_oe    <= 1'b1;
                        if (r_reg_otp) begin
                            if (r_unlocked) begin
                                r_otp_cmd <= r_shift;
                                r_rd      <= (r_shift == CMD_RD);
                                r_wr      <= (r_shift == CMD_WR);
                            end else begin
                                r_rej <= 1'b1;
                            end
                        end else if (w_match) begin
                            if (w_idx_eff == 3'd5) begin
                                r_unlocked <= 1'b1;
                                r_idx      <= 3'd0;
                            end else begin
                                r_unlocked <= 1'b0;
                                r_idx      <= w_idx_eff + 3'd1;
                            end
                        end else begin
                            r_unlocked <= 1'b0;
                            r_idx      <= 3'd0;
                        end
                    end
                    S_DEV_ACK, S_REG_ACK, S_DATA_ACK: if (w_scl_fall) begin
                        r_oe    <= 1'b0;
                        r_cnt   <= 3'd0;
                        r_state <= (r_state == S_DEV_ACK) ? S_REG_ADDR : S_DATA;
                    end
                endcase
            end
        end
    end

    assign i2c_sda_oe   = r_oe;
    assign unlocked     = r_unlocked;
    assign otp_cmd      = r_otp_cmd;
    assign otp_rd_pulse = r_rd;
    assign otp_wr_pulse = r_wr;
    assign cmd_reject   = r_rej;
    assign busy         = r_busy;

endmodule

// File: tb/tb_i2c_slave_passcode.sv
// Directed bench for i2c_slave_passcode: bit-banged I2C master with
// hand-computed ACK patterns, unlock state and OTP pulse counts.
module tb_i2c_slave_passcode;

    localparam int Q = 50;

    logic       clk_sda = 1'b0;
    logic       rst_n   = 1'b0;
    logic       r_scl   = 1'b1;
    logic       r_sda_m = 1'b1;
    logic       w_sda_bus;
    logic       i2c_sda_oe, unlocked, busy;
    logic       otp_rd_pulse, otp_wr_pulse, cmd_reject;
    logic [7:0] otp_cmd;

    int checks   = 0;
    int failures = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;
    int rej_cnt  = 0;

    assign w_sda_bus = r_sda_m & ~i2c_sda_oe;

    i2c_slave_passcode dut (
        .clk_sda     (clk_sda),
        .rst_n       (rst_n),
        .i2c_scl     (r_scl),
        .i2c_sda_in  (w_sda_bus),
        .i2c_sda_oe  (i2c_sda_oe),
        .unlocked    (unlocked),
        .otp_cmd     (otp_cmd),
        .otp_rd_pulse(otp_rd_pulse),
        .otp_wr_pulse(otp_wr_pulse),
        .cmd_reject  (cmd_reject),
        .busy        (busy)
    );

    always #5 clk_sda = ~clk_sda;

    // A pulse longer than one cycle is counted more than once
    always @(negedge clk_sda) begin
        if (otp_rd_pulse) rd_cnt++;
        if (otp_wr_pulse) wr_cnt++;
        if (cmd_reject)   rej_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic i2c_start();
        r_sda_m = 1'b1; #Q;
        r_scl   = 1'b1; #Q;
        r_sda_m = 1'b0; #Q;
        r_scl   = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        r_sda_m = 1'b0; #Q;
        r_scl   = 1'b1; #Q;
        r_sda_m = 1'b1; #Q;
    endtask

    task automatic wbit(input logic b);
        r_sda_m = b; #Q;
        r_scl   = 1'b1; #(2*Q);
        r_scl   = 1'b0; #Q;
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(b[i]);
        r_sda_m = 1'b1; #Q;
        r_scl   = 1'b1; #Q;
        ack     = i2c_sda_oe;
        #Q;
        r_scl   = 1'b0; #Q;
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] r,
                         input logic [7:0] d, output logic [2:0] acks);
        i2c_start();
        wbyte(a, acks[2]);
        wbyte(r, acks[1]);
        wbyte(d, acks[0]);
        i2c_stop();
        #(2*Q);
    endtask

    logic [7:0] good [6] = '{8'h50, 8'h48, 8'h53, 8'h47, 8'h4E, 8'h58};
    logic [7:0] bad  [6] = '{8'h50, 8'h48, 8'h51, 8'h47, 8'h4E, 8'h58};

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [2:0] acks;
        logic [7:0] a;
        a = 8'h11;
        @(negedge clk_sda);
        #(4*Q);
        check("rst_oe", i2c_sda_oe, 0);
        check("rst_unlocked", unlocked, 0);
        check("rst_otp_cmd", otp_cmd, 8'h01);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        #(4*Q);

        frame(8'h14, 8'h04, 8'h11, acks);
        check("locked_acks", acks, 3'b111);
        check("locked_rej", rej_cnt, 1);
        check("locked_cmd", otp_cmd, 8'h01);
        check("locked_wr", wr_cnt, 0);
        check("locked_unl", unlocked, 0);

        for (int i = 0; i < 6; i++) begin
            frame(8'h14, 8'h05, bad[i], acks);
            check("bad_acks", acks, 3'b111);
        end
        check("bad_unl", unlocked, 0);

        for (int i = 0; i < 6; i++) begin
            frame(8'h14, 8'h05, good[i], acks);
            check("good_acks", acks, 3'b111);
            check("good_unl", unlocked, (i == 5) ? 1 : 0);
        end
        check("pass_rd", rd_cnt, 0);
        check("pass_wr", wr_cnt, 0);
        check("pass_rej", rej_cnt, 1);

        frame(8'h14, 8'h04, 8'h00, acks);
        check("rd_acks", acks, 3'b111);
        check("rd_cmd", otp_cmd, 8'h00);
        check("rd_cnt", rd_cnt, 1);
        frame(8'h14, 8'h04, 8'h11, acks);
        check("wr_cmd", otp_cmd, 8'h11);
        check("wr_cnt", wr_cnt, 1);
        frame(8'h14, 8'h04, 8'h01, acks);
        check("nop_cmd", otp_cmd, 8'h01);
        check("nop_rd", rd_cnt, 1);
        check("nop_wr", wr_cnt, 1);
        check("nop_rej", rej_cnt, 1);

        frame(8'h16, 8'h04, 8'h00, acks);
        check("nack_addr", acks, 3'b000);
        frame(8'h15, 8'h04, 8'h00, acks);
        check("nack_read", acks, 3'b000);
        frame(8'h14, 8'h07, 8'h00, acks);
        check("nack_reg", acks, 3'b100);
        check("nack_cmd", otp_cmd, 8'h01);
        check("nack_rd", rd_cnt, 1);
        check("nack_unl", unlocked, 1);
        frame(8'h14, 8'h04, 8'h00, acks);
        check("after_nack_acks", acks, 3'b111);
        check("after_nack_rd", rd_cnt, 2);

        i2c_start();
        check("busy_start", busy, 1);
        wbyte(8'h14, acks[2]);
        wbyte(8'h04, acks[1]);
        for (int i = 7; i >= 4; i--) wbit(a[i]);
        i2c_start();
        i2c_stop();
        #(2*Q);
        check("abort_cmd", otp_cmd, 8'h00);
        check("abort_wr", wr_cnt, 1);
        check("abort_busy", busy, 0);

        a = 8'h14;
        i2c_start();
        for (int i = 7; i >= 0; i--) wbit(a[i]);
        r_sda_m = 1'b1; #Q;
        r_scl   = 1'b1; #Q;
        check("mid_oe", i2c_sda_oe, 1);
        rst_n = 1'b0;
        #1;
        check("arst_oe", i2c_sda_oe, 0);
        check("arst_unl", unlocked, 0);
        check("arst_cmd", otp_cmd, 8'h01);
        check("arst_busy", busy, 0);
        #(Q-1);
        rst_n = 1'b1;
        #(2*Q);

        frame(8'h14, 8'h04, 8'h00, acks);
        check("post_rst_acks", acks, 3'b111);
        check("post_rst_rej", rej_cnt, 2);
        check("post_rst_rd", rd_cnt, 2);
        check("post_rst_cmd", otp_cmd, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_slave_passcode.md
Name: i2c_slave_passcode

Overview:
- I2C write-only responder at device address 0x0A; the target end of the passcode/OTP-command master.
- Oversamples SCL/SDA on clk_sda, decodes START/STOP/bytes, ACKs valid frames.
- Checks the six-byte passcode written to register 0x05; gates OTP read/write commands written to register 0x04.
- Sits between the I2C pads and the OTP controller; its outputs are unlock status and one-cycle OTP request pulses.

Parameters:
- DEV_ADDR, 7'h0A, 7-bit device address answered.
- REG_PASSCODE, 8'h05, passcode register address.
- REG_OTP, 8'h04, OTP command register address.
- PASSCODE, 48'h50_48_53_47_4E_58, expected bytes, MSB byte first ("PHSGNX").
- CMD_RD, 8'h00, OTP read command.
- CMD_WR, 8'h11, OTP write command.
- CMD_NOP, 8'h01, no-operation command.

Ports:
- clk_sda  in  1  system sampling clock; must be >= 8x SCL frequency.
- rst_n  in  1  reset; asynchronous, active-low.
- i2c_scl  in  1  SCL from bus (asynchronous).
- i2c_sda_in  in  1  SDA from bus (asynchronous).
- i2c_sda_oe  out  1  1 = pull SDA low (ACK); 0 = release.
- unlocked  out  1  passcode accepted.
- otp_cmd  out  8  last accepted OTP command.
- otp_rd_pulse  out  1  one-cycle OTP read request.
- otp_wr_pulse  out  1  one-cycle OTP write request.
- cmd_reject  out  1  one-cycle pulse: OTP command written while locked.
- busy  out  1  high from START to STOP.

Behaviour:
- Reset values: i2c_sda_oe=0, unlocked=0, otp_cmd=CMD_NOP, all pulses 0, busy=0, FSM=IDLE, passcode index=0.
- Input path: 2-FF synchronizer on SCL and SDA, then a one-cycle-delayed copy for edge detect. An event is seen 3 clk_sda cycles after the pin change.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high.
- Bits are sampled on the detected SCL rising edge, MSB first. A 3-bit counter counts 8 bits per byte.
- FSM states: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, DATA, DATA_ACK, IGNORE.
- START from any state (including repeated START): go to DEV_ADDR, clear the bit counter, discard any partial byte, release SDA.
- STOP from any state: go to IDLE, release SDA, clear busy.
- DEV_ADDR, after 8 bits:
  - address==DEV_ADDR and R/W=0: go to DEV_ACK.
  - otherwise (reads unsupported): go to IGNORE (NACK = SDA released).
- ACK timing, all ACK states: on the SCL falling edge after bit 8, assert i2c_sda_oe. Hold it through the 9th SCL high phase; deassert on the next SCL falling edge, then advance.
- DEV_ACK -> REG_ADDR.
- REG_ADDR, after 8 bits:
  - REG_PASSCODE or REG_OTP: latch the register address, go to REG_ACK.
  - any other address: go to IGNORE.
- REG_ACK -> DATA.
- DATA, after 8 bits, the byte is committed at the SCL falling edge that starts the ACK; then go to DATA_ACK. DATA_ACK -> DATA.
- The register address does not auto-increment: extra bytes in the same frame target the same register.
- IGNORE: SDA released; wait for START or STOP.
- Passcode commit rule, for a write to REG_PASSCODE:
  - If unlocked=1: clear unlocked and set index=0 first, then evaluate the byte.
  - If byte == PASSCODE byte[index]: index+1. When index reaches 6, set unlocked=1 and index=0.
  - Mismatch: index=0. A mismatching byte is not re-evaluated as byte 0.
- OTP command commit rule, for a write to REG_OTP:
  - unlocked=1: otp_cmd <= byte. If CMD_RD, pulse otp_rd_pulse; if CMD_WR, pulse otp_wr_pulse; any other value, no pulse.
  - unlocked=0: otp_cmd unchanged, pulse cmd_reject.
  - The byte is always ACKed, whether locked or unlocked.
- All pulses are exactly 1 clk_sda cycle, coincident with the commit.
- A STOP or START before bit 8 commits nothing.
- Asynchronous reset mid-frame returns everything to reset values immediately, including releasing SDA.

Optional Feature:
- Macro: I2C_SLV_GLITCH_FILTER_EN.
- Defined: adds a 3-sample majority filter after the synchronizers on both SCL and SDA. Edge detection latency becomes 5 clk_sda cycles; single-cycle glitches are rejected.
- Undefined: no filter, 3-cycle latency; a single-cycle glitch on SCL is treated as a real edge.

Test Plan:
- Six frames [0x0A W][0x05][P,H,S,G,N,X in order] -> every address/data byte ACKed; unlocked=1 after the 6th commit; no pulses.
- Unlocked, then frame [0x0A W][0x04][0x00] -> otp_cmd=0x00, otp_rd_pulse high for 1 cycle; repeat with 0x11 -> otp_wr_pulse; with 0x01 -> otp_cmd=0x01, no pulse.
- From reset, [0x0A W][0x04][0x11] -> ACKed, cmd_reject pulse, otp_cmd stays 0x01, unlocked=0.
- Passcode sequence P,H,Q,G,N,X -> index cleared at Q; unlocked stays 0; a following full correct sequence unlocks.
- Address 0x0B, a read to 0x0A, and register 0x07 -> SDA released at the 9th clock (NACK); no state change; the next valid frame is accepted.
- START after 4 data bits, then STOP and rst_n pulse while i2c_sda_oe=1 -> no commit; reset forces i2c_sda_oe=0, unlocked=0, otp_cmd=0x01.
